id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute.
- Captures the main-decoder control bundle, register operands, immediate, register specifiers and PC+4.
- Detects load-use hazards and drives the decoder's controlmux low to zero the control word. Also freezes PC and IF/ID on a hazard.
- Handles branch flush and downstream stall, and counts inserted bubbles.

Parameters:
- DATA_W, 32, width of operand, immediate and PC paths.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_RegDst, id_Jump, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  decoder control outputs
- id_ALUOp  in  2  decoder ALUOp
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_rdata1, id_rdata2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of ID instruction
- flush  in  1  taken branch/jump resolved; kill ID instruction
- ex_stall  in  1  downstream cannot accept; hold stage
- controlmux  out  1  to decoder; 0 forces all controls to zero
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register load enable
- ex_RegDst, ex_Jump, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  out  1 each  registered controls
- ex_ALUOp  out  2  registered ALUOp
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W each  registered data
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (async, rst_n=0): every ex_* output = 0, ex_valid=0, bubble_cnt=0, applied immediately and independent of clk. Combinational outputs follow from the zeroed state: controlmux=1, pc_write=1, ifid_write=1.
- hazard (combinational): ex_valid & ex_MemRead & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- controlmux = ~hazard.
- pc_write = ifid_write = ~hazard & ~ex_stall.
- Register update priority at each rising clk edge (highest first):
  1. flush: load bubble (all ctrl 0, ex_valid=0, data/specifiers 0); bubble_cnt += 1. Flush overrides ex_stall.
  2. ex_stall: hold every ex_* register unchanged; no count.
  3. hazard: load bubble; bubble_cnt += 1.
  4. otherwise: load all id_* inputs; ex_valid = id_valid.
- Latency: one cycle from ID inputs to ex_* outputs.
- Hazard lasts exactly one cycle in the absence of stall, because the bubble clears ex_MemRead.
- Under ex_stall with hazard=1: hold takes priority, no bubble is loaded and no count is taken. The hazard is re-evaluated once the stall releases.
- A bubble loaded with id_valid=0 still counts; the count is of bubbles the stage inserts, not of lost instructions.
- bubble_cnt saturates at all-ones; it never wraps.
- Register $0 never creates a hazard.
- Reset asserted mid-stall or mid-hazard clears state at once. The first post-reset edge performs a normal load.

Test Plan:
- Reset then stream add (ctrl RegDst=1, ALUOp=10, RegWrite=1, rdata1=0x5, rdata2=0x7) with id_valid=1 -> one edge later ex_RegDst=1, ex_ALUOp=10, ex_RegWrite=1, ex_rdata1=0x5, ex_valid=1; controlmux=1, pc_write=1.
- lw $8 loads into EX (ex_MemRead=1, ex_rt=8), then ID add with id_rs=8 -> controlmux=0, pc_write=0, ifid_write=0 that cycle. Next edge all ex ctrl=0, ex_valid=0, bubble_cnt=1. Following cycle controlmux=1.
- lw $0 in EX, ID id_rt=0 -> controlmux stays 1, no bubble, bubble_cnt unchanged.
- Valid sw in EX, assert ex_stall 3 cycles with changing ID inputs -> ex_* constant for 3 edges, pc_write=0, bubble_cnt unchanged. Release -> ID values load on next edge.
- flush and ex_stall together, valid instruction in EX -> next edge ex_valid=0, all ctrl 0, bubble_cnt increments by 1.
- CNT_W=2, force 5 hazard/flush bubbles -> bubble_cnt sequence 1,2,3,3,3. Pulse rst_n low mid-run between edges -> all ex_* and bubble_cnt read 0 before the next clk edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoder control bundle, register operands, immediate, register
// specifiers and PC+4 from ID and presents them to EX one cycle later. A load
// in EX whose destination (rt) is read by the valid instruction in ID raises a
// hazard. The hazard zeroes the decoder controls (controlmux), freezes PC and
// IF/ID, and loads a bubble into EX.
//
// Update priority at each edge: flush > ex_stall (hold) > hazard > normal load.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_* (controls, ALUOp, valid)   decoder outputs for the ID instruction
//   id_rs/rt/rd, id_rdata1/2        register specifiers and read data
//   id_imm, id_pc4                  sign-extended immediate, PC+4
//   flush                           kill the ID instruction (taken branch/jump)
//   ex_stall                        EX cannot accept; hold this stage
//   controlmux                      to decoder; 0 forces all controls to zero
//   pc_write, ifid_write            PC and IF/ID load enables
//   ex_*                            registered copies presented to EX
//   bubble_cnt                      saturating count of bubbles inserted
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_RegDst,
  input  logic              id_Jump,
  input  logic              id_Branch,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              controlmux,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ex_RegDst,
  output logic              ex_Jump,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              reg_dst;
    logic              jump;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [1:0]        alu_op;
    logic              valid;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } ex_t;

  ex_t              ex_q, ex_d, id_bundle;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             insert_bubble;

  always_comb begin
    id_bundle            = '0;
    id_bundle.reg_dst    = id_RegDst;
    id_bundle.jump       = id_Jump;
    id_bundle.branch     = id_Branch;
    id_bundle.mem_read   = id_MemRead;
    id_bundle.mem_to_reg = id_MemtoReg;
    id_bundle.mem_write  = id_MemWrite;
    id_bundle.alu_src    = id_ALUSrc;
    id_bundle.reg_write  = id_RegWrite;
    id_bundle.alu_op     = id_ALUOp;
    id_bundle.valid      = id_valid;
    id_bundle.rs         = id_rs;
    id_bundle.rt         = id_rt;
    id_bundle.rd         = id_rd;
    id_bundle.rdata1     = id_rdata1;
    id_bundle.rdata2     = id_rdata2;
    id_bundle.imm        = id_imm;
    id_bundle.pc4        = id_pc4;
  end

  // Load-use: a load in EX writes rt, which the ID instruction reads. $0 never
  // carries a dependency since writes to it are discarded.
  assign hazard = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rt != 5'd0) &
                  ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

  assign controlmux = ~hazard;
  assign pc_write   = ~hazard & ~ex_stall;
  assign ifid_write = ~hazard & ~ex_stall;

  // Flush beats stall; a stalled hazard is held and re-evaluated afterwards.
  assign insert_bubble = flush | (~ex_stall & hazard);

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (insert_bubble) begin
      ex_d = '0;
    end else if (!ex_stall) begin
      ex_d = id_bundle;
    end
    if (insert_bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_RegDst   = ex_q.reg_dst;
  assign ex_Jump     = ex_q.jump;
  assign ex_Branch   = ex_q.branch;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemtoReg = ex_q.mem_to_reg;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_ALUOp    = ex_q.alu_op;
  assign ex_valid    = ex_q.valid;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_rdata1   = ex_q.rdata1;
  assign ex_rdata2   = ex_q.rdata2;
  assign ex_imm      = ex_q.imm;
  assign ex_pc4      = ex_q.pc4;
  assign bubble_cnt  = cnt_q;

endmodule
